sim_ctrl: RTL and testbench
===========================

SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 Parameter IRQ_DLY_DEF, default 20: reset value of the DLY register, in clk cycles from WFI detection to meip assertion.
REQ-002 Parameter IRQ_LEN_DEF, default 10: reset value of the LEN register, in clk cycles meip stays high.
REQ-003 Parameter TIMEOUT, default 100000: watchdog limit in clk cycles.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 cs  input  1  bus access select, one-cycle request.
REQ-007 we  input  4  byte write enables; 0 means read.
REQ-008 addr  input  12  byte address; bits [1:0] ignored.
REQ-009 di  input  32  write data.
REQ-010 do  output  32  read data, registered.
REQ-011 wfi  input  1  core has entered WFI, from the id2exe_wfi stage signal.
REQ-012 meip  output  1  injected machine external interrupt.
REQ-013 sim_done  output  1  test-end flag latched.
REQ-014 end_code  output  32  END_CODE register value.
REQ-015 timeout  output  1  watchdog expired.

Function
REQ-016 Register map: 0x000 CTRL (bit0 ARM, bit1 WDEN), 0x004 DLY[15:0], 0x008 LEN[15:0], 0x00C CYCLE (read-only, free-running 32-bit), 0xFF8 END_CODE, 0xFFC END_FLAG.
REQ-017 A write takes effect at the clk edge where cs=1, and only the bytes with the matching we bit are updated.
REQ-018 A read (cs=1, we=0) returns data on do in the following cycle; do holds its value when no read is issued.
REQ-019 Reads of unmapped addresses return 0, and writes to them are ignored.
REQ-020 END_FLAG reads back {31'b0, sim_done}.
REQ-021 sim_done is set by a write of value 1 to END_FLAG (byte 0 enabled); it is cleared only by rst.
REQ-022 END_CODE writes are ignored once sim_done=1; end_code always mirrors END_CODE.
REQ-023 A single write that sets END_FLAG and a write to END_CODE in the same cycle cannot occur; END_CODE must be written before END_FLAG.
REQ-024 Injection FSM states: IDLE, WAITWFI, DELAY, ASSERT.
REQ-025 IDLE -> WAITWFI when ARM=1.
REQ-026 WAITWFI -> DELAY on the first cycle wfi=1, and the counter loads DLY.
REQ-027 DELAY decrements each cycle; the FSM goes to ASSERT when the counter is 0, and the counter loads LEN.
REQ-028 ASSERT drives meip=1 and decrements; the FSM goes to IDLE when the counter is 0, and hardware clears ARM in the same cycle.
REQ-029 meip=1 only in ASSERT; a LEN of 0 gives exactly 1 cycle of meip.
REQ-030 Latency rule: with DLY=D and LEN=L, meip rises D+1 cycles after the first wfi=1 sample and stays high L+1 cycles; a DLY of 0 gives meip on the cycle after the wfi sample.
REQ-031 wfi deassertion during DELAY does not abort the sequence.
REQ-032 Writing ARM=0 in any state returns the FSM to IDLE next cycle and deasserts meip.
REQ-033 A CTRL write that lands in the same cycle as the hardware ARM clear wins.
REQ-034 CYCLE increments every cycle and wraps from 0xFFFFFFFF to 0.
REQ-035 The watchdog counter increments while WDEN=1 and sim_done=0.
REQ-036 timeout sets when the watchdog counter reaches TIMEOUT-1 and is sticky until rst; the counter saturates there.
REQ-037 Once sim_done=1, neither the watchdog nor timeout changes further.

Reset
REQ-038 While rst=1: do=0, meip=0, sim_done=0, end_code=0, timeout=0.
REQ-039 While rst=1: CTRL=0, DLY=IRQ_DLY_DEF, LEN=IRQ_LEN_DEF, CYCLE=0, watchdog=0, FSM=IDLE.
REQ-040 rst asserted mid-sequence, including in ASSERT, drops meip the cycle after the sampling edge and forgets all pending state.

Verification
REQ-041 Write END_CODE=0x0000_0001 then END_FLAG=1 -> sim_done=1 next cycle, end_code=0x1; a later END_CODE write of 0xDEAD leaves end_code=0x1.
REQ-042 Defaults, CTRL=1, wfi pulsed at cycle T -> meip high on cycles T+21..T+31 (11 cycles), then CTRL reads 0.
REQ-043 DLY=0, LEN=0, ARM=1, wfi=1 -> a single-cycle meip on the cycle after the wfi sample.
REQ-044 WDEN=1 with TIMEOUT=50 and no END_FLAG -> timeout rises on cycle 50 and stays high; a run with END_FLAG written at cycle 30 -> timeout stays 0.
REQ-045 Byte write we=4'b0010, di=0x0000_AB00 to DLY=0x0014 -> DLY reads 0xAB14 one cycle after the read request.
REQ-046 rst pulsed during ASSERT -> meip=0 the next cycle, DLY reads 20, FSM idle with no meip on a subsequent wfi.

Source files
------------

// File: rtl/sim_ctrl.sv
// Simulation control block: bus-mapped registers, WFI-triggered delayed
// machine interrupt injection, sticky test-end latch and a watchdog timer.
module sim_ctrl #(
    parameter int IRQ_DLY_DEF = 20,
    parameter int IRQ_LEN_DEF = 10,
    parameter int TIMEOUT     = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic [3:0]  we_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] di_i,
    output logic [31:0] do_o,
    input  logic        wfi_i,
    output logic        meip_o,
    output logic        sim_done_o,
    output logic [31:0] end_code_o,
    output logic        timeout_o
);

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

    localparam logic [9:0] A_CTRL     = 10'h000;
    localparam logic [9:0] A_DLY      = 10'h001;
    localparam logic [9:0] A_LEN      = 10'h002;
    localparam logic [9:0] A_CYCLE    = 10'h003;
    localparam logic [9:0] A_END_CODE = 10'h3FE;
    localparam logic [9:0] A_END_FLAG = 10'h3FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAITWFI,
        ST_DELAY,
        ST_ASSERT
    } state_t;

    state_t         state_q;
    logic [15:0]    cnt_q;
    logic           meip_q;

    logic           arm_q, arm_d;
    logic           wden_q, wden_d;
    logic [15:0]    dly_q, dly_d;
    logic [15:0]    len_q, len_d;
    logic [31:0]    cycle_q;
    logic [31:0]    endCode_q, endCode_d;
    logic           simDone_q, simDone_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           timeout_q, timeout_d;
    logic [31:0]    do_q;
    logic [31:0]    rdData;

    logic [9:0]     word;
    logic           wrReq;
    logic           rdReq;
    logic           ctrlWr;
    logic           dlyWr;
    logic           lenWr;
    logic           endCodeWr;
    logic           endFlagWr;
    logic           armWrZero;
    logic           hwArmClr;
    logic           unusedAddrBits;

    function automatic logic [15:0] merge16(input logic [15:0] oldVal,
                                            input logic [15:0] newVal,
                                            input logic [1:0]  be);
        return {be[1] ? newVal[15:8] : oldVal[15:8],
                be[0] ? newVal[7:0]  : oldVal[7:0]};
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  be);
        return {merge16(oldVal[31:16], newVal[31:16], be[3:2]),
                merge16(oldVal[15:0],  newVal[15:0],  be[1:0])};
    endfunction

    // Byte-lane bits [1:0] of the address carry no meaning for word registers.
    assign unusedAddrBits = ^addr_i[1:0];

    assign word      = addr_i[11:2];
    assign wrReq     = cs_i && (we_i != 4'b0000);
    assign rdReq     = cs_i && (we_i == 4'b0000);
    assign ctrlWr    = wrReq && we_i[0] && (word == A_CTRL);
    assign dlyWr     = wrReq && (word == A_DLY);
    assign lenWr     = wrReq && (word == A_LEN);
    assign endCodeWr = wrReq && (word == A_END_CODE);
    assign endFlagWr = wrReq && we_i[0] && (word == A_END_FLAG);
    assign armWrZero = ctrlWr && !di_i[0];
    assign hwArmClr  = (state_q == ST_ASSERT) && (cnt_q == 16'd0);

    always_comb begin
        arm_d     = arm_q;
        wden_d    = wden_q;
        dly_d     = dly_q;
        len_d     = len_q;
        endCode_d = endCode_q;
        simDone_d = simDone_q;
        if (hwArmClr) begin
            arm_d = 1'b0;
        end
        // A software CTRL write overrides the end-of-pulse ARM clear.
        if (ctrlWr) begin
            arm_d  = di_i[0];
            wden_d = di_i[1];
        end
        if (dlyWr) begin
            dly_d = merge16(dly_q, di_i[15:0], we_i[1:0]);
        end
        if (lenWr) begin
            len_d = merge16(len_q, di_i[15:0], we_i[1:0]);
        end
        if (endCodeWr && !simDone_q) begin
            endCode_d = merge32(endCode_q, di_i, we_i);
        end
        if (endFlagWr && di_i[0]) begin
            simDone_d = 1'b1;
        end
    end

    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (wden_q && !simDone_q) begin
            if (wdog_q != WD_LAST) begin
                wdog_d = wdog_q + WD_ONE;
            end
            if (wdog_d == WD_LAST) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdData = 32'h0;
        case (word)
            A_CTRL:     rdData = {30'h0, wden_q, arm_q};
            A_DLY:      rdData = {16'h0, dly_q};
            A_LEN:      rdData = {16'h0, len_q};
            A_CYCLE:    rdData = cycle_q;
            A_END_CODE: rdData = endCode_q;
            A_END_FLAG: rdData = {31'h0, simDone_q};
            default:    rdData = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arm_q     <= 1'b0;
            wden_q    <= 1'b0;
            dly_q     <= 16'(IRQ_DLY_DEF);
            len_q     <= 16'(IRQ_LEN_DEF);
            cycle_q   <= 32'h0;
            endCode_q <= 32'h0;
            simDone_q <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            do_q      <= 32'h0;
        end else begin
            arm_q     <= arm_d;
            wden_q    <= wden_d;
            dly_q     <= dly_d;
            len_q     <= len_d;
            cycle_q   <= cycle_q + 32'd1;
            endCode_q <= endCode_d;
            simDone_q <= simDone_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            if (rdReq) begin
                do_q <= rdData;
            end
        end
    end

    // The counter holds DLY while waiting and LEN while meip is driven.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            meip_q  <= 1'b0;
        end else if (armWrZero) begin
            state_q <= ST_IDLE;
            meip_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_q) begin
                        state_q <= ST_WAITWFI;
                    end
                end
                ST_WAITWFI: begin
                    if (wfi_i) begin
                        state_q <= ST_DELAY;
                        cnt_q   <= dly_q;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_ASSERT;
                        cnt_q   <= len_q;
                        meip_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                        meip_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    meip_q  <= 1'b0;
                end
            endcase
        end
    end

    assign do_o       = do_q;
    assign meip_o     = meip_q;
    assign sim_done_o = simDone_q;
    assign end_code_o = endCode_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a timestamp-based model.
module tb_sim_ctrl;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] di;
    logic [31:0] doData;
    logic        wfi;
    logic        meip;
    logic        simDone;
    logic [31:0] endCode;
    logic        timeout;

    int nChecks = 0;
    int nFails  = 0;

    sim_ctrl #(
        .IRQ_DLY_DEF(20),
        .IRQ_LEN_DEF(10),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cs_i      (cs),
        .we_i      (we),
        .addr_i    (addr),
        .di_i      (di),
        .do_o      (doData),
        .wfi_i     (wfi),
        .meip_o    (meip),
        .sim_done_o(simDone),
        .end_code_o(endCode),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    // Reference state: plain registers plus edge timestamps for the injector.
    bit          modelValid = 1'b0;
    longint      n;
    bit          mArm, mWden, mSimDone, mTimeout, mMeip;
    logic [15:0] mDly, mLen;
    logic [31:0] mCycle, mEndCode, mDo;
    int          mWdog;
    bit          seqWfi, seqEndKnown;
    longint      armEdge, startE, endE;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a[11:2])
            10'h000: return {30'h0, mWden, mArm};
            10'h001: return {16'h0, mDly};
            10'h002: return {16'h0, mLen};
            10'h003: return mCycle;
            10'h3FE: return mEndCode;
            10'h3FF: return {31'h0, mSimDone};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStep();
        bit         hwClear;
        bit         wr;
        logic [9:0] w;
        if (rst) begin
            modelValid = 1'b1;
            n = 0; mArm = 0; mWden = 0; mDly = 16'd20; mLen = 16'd10;
            mCycle = 0; mEndCode = 0; mSimDone = 0; mWdog = 0; mTimeout = 0;
            mDo = 0; mMeip = 0; seqWfi = 0; seqEndKnown = 0; armEdge = 0;
            return;
        end
        if (!modelValid) return;
        n++;
        w  = addr[11:2];
        wr = cs && (we != 4'b0000);
        if (cs && (we == 4'b0000)) mDo = modelRead(addr);
        hwClear = 1'b0;
        if (mArm) begin
            if (!seqWfi) begin
                if ((n >= armEdge + 2) && wfi) begin
                    seqWfi = 1'b1;
                    startE = n + longint'(mDly) + 1;
                end
            end else if (!seqEndKnown) begin
                if (n == startE) begin
                    seqEndKnown = 1'b1;
                    endE = n + longint'(mLen);
                end
            end else if (n == endE + 1) begin
                hwClear = 1'b1;
            end
        end
        if (hwClear) begin
            mArm = 0; seqWfi = 0; seqEndKnown = 0;
        end
        if (mWden && !mSimDone) begin
            if (mWdog < TMO - 1) mWdog++;
            if (mWdog == TMO - 1) mTimeout = 1'b1;
        end
        mCycle = mCycle + 32'd1;
        if (wr && we[0] && w == 10'h000) begin
            if (!di[0]) begin
                mArm = 0; seqWfi = 0; seqEndKnown = 0;
            end else if (!mArm) begin
                mArm = 1; armEdge = n; seqWfi = 0; seqEndKnown = 0;
            end
            mWden = di[1];
        end
        if (wr && w == 10'h001) begin
            for (int i = 0; i < 2; i++) if (we[i]) mDly[8*i +: 8] = di[8*i +: 8];
        end
        if (wr && w == 10'h002) begin
            for (int i = 0; i < 2; i++) if (we[i]) mLen[8*i +: 8] = di[8*i +: 8];
        end
        if (wr && w == 10'h3FE && !mSimDone) begin
            for (int i = 0; i < 4; i++) if (we[i]) mEndCode[8*i +: 8] = di[8*i +: 8];
        end
        if (wr && we[0] && w == 10'h3FF && di[0]) mSimDone = 1'b1;
        mMeip = mArm && seqEndKnown && (n >= startE) && (n <= endE);
    endtask

    always @(posedge clk) begin
        modelStep();
        #1;
        if (modelValid) begin
            checkOutput("cyc_do",       doData,  mDo);
            checkOutput("cyc_meip",     meip,    mMeip);
            checkOutput("cyc_sim_done", simDone, mSimDone);
            checkOutput("cyc_end_code", endCode, mEndCode);
            checkOutput("cyc_timeout",  timeout, mTimeout);
        end
    end

    task automatic applyStimulus(input logic [11:0] a, input logic [3:0] b, input logic [31:0] d);
        cs = 1'b1; addr = a; we = b; di = d;
        @(negedge clk);
        cs = 1'b0; we = 4'b0000;
    endtask

    task automatic readReg(input logic [11:0] a, output logic [31:0] d);
        applyStimulus(a, 4'b0000, 32'h0);
        d = doData;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: simulation did not complete");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        logic [31:0] rd;
        bit          sawMeip;
        rst = 1'b1; cs = 1'b0; we = 4'b0000; addr = 12'h0; di = 32'h0; wfi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_do",       doData,  32'h0);
        checkOutput("rst_meip",     meip,    32'h0);
        checkOutput("rst_sim_done", simDone, 32'h0);
        checkOutput("rst_end_code", endCode, 32'h0);
        checkOutput("rst_timeout",  timeout, 32'h0);
        readReg(12'h004, rd); checkOutput("rst_dly",  rd, 32'h14);
        readReg(12'h008, rd); checkOutput("rst_len",  rd, 32'h0A);
        readReg(12'h000, rd); checkOutput("rst_ctrl", rd, 32'h0);

        applyStimulus(12'h004, 4'b0010, 32'h0000AB00);
        readReg(12'h004, rd); checkOutput("byte_write_dly", rd, 32'h0000AB14);
        applyStimulus(12'h004, 4'b0011, 32'd20);

        applyStimulus(12'h000, 4'b0001, 32'h1);
        @(negedge clk);
        wfi = 1'b1;
        @(negedge clk);
        wfi = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            checkOutput($sformatf("default_meip_k%0d", k), meip, (k >= 21 && k <= 31));
        end
        readReg(12'h000, rd); checkOutput("ctrl_after_pulse", rd, 32'h0);

        applyStimulus(12'h004, 4'b0011, 32'h0);
        applyStimulus(12'h008, 4'b0011, 32'h0);
        wfi = 1'b1;
        applyStimulus(12'h000, 4'b0001, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("zero_meip_k%0d", k), meip, (k == 3));
        end
        wfi = 1'b0;
        readReg(12'h000, rd); checkOutput("ctrl_after_zero", rd, 32'h0);

        applyStimulus(12'h004, 4'b0011, 32'd5);
        applyStimulus(12'h008, 4'b0011, 32'd10);
        applyStimulus(12'h000, 4'b0001, 32'h1);
        @(negedge clk);
        wfi = 1'b1;
        @(negedge clk);
        wfi = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("meip_before_rst", meip, 32'h1);
        pulseReset();
        checkOutput("meip_after_rst", meip, 32'h0);
        readReg(12'h004, rd); checkOutput("dly_after_rst",  rd, 32'd20);
        readReg(12'h000, rd); checkOutput("ctrl_after_rst", rd, 32'h0);
        wfi = 1'b1;
        @(negedge clk);
        wfi = 1'b0;
        sawMeip = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (meip) sawMeip = 1'b1;
        end
        checkOutput("no_meip_when_idle", sawMeip, 32'h0);

        pulseReset();
        applyStimulus(12'h000, 4'b0001, 32'h2);
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            checkOutput($sformatf("wdog_c%0d", c), timeout, (c >= 50));
        end

        pulseReset();
        applyStimulus(12'h000, 4'b0001, 32'h2);
        repeat (28) @(negedge clk);
        applyStimulus(12'hFFC, 4'b0001, 32'h1);
        repeat (60) @(negedge clk);
        checkOutput("wdog_stopped_timeout", timeout, 32'h0);
        checkOutput("wdog_stopped_done",    simDone, 32'h1);

        pulseReset();
        applyStimulus(12'hFF8, 4'b1111, 32'h1);
        applyStimulus(12'hFFC, 4'b0001, 32'h1);
        checkOutput("end_sim_done", simDone, 32'h1);
        checkOutput("end_code",     endCode, 32'h1);
        applyStimulus(12'hFF8, 4'b1111, 32'hDEAD);
        checkOutput("end_code_locked", endCode, 32'h1);
        readReg(12'hFFC, rd); checkOutput("end_flag_read", rd, 32'h1);
        applyStimulus(12'h010, 4'b1111, 32'hFFFF_FFFF);
        readReg(12'h010, rd); checkOutput("unmapped_read", rd, 32'h0);

        pulseReset();
        for (int i = 0; i < 4000; i++) begin
            int op;
            op  = $urandom_range(0, 15);
            wfi = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 399) == 0);
            cs  = 1'b0; we = 4'b0000;
            case (op)
                0, 1: begin
                    cs = 1'b1; addr = 12'h000; we = 4'($urandom_range(0, 15));
                    di = $urandom; di[0] = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    cs = 1'b1; addr = 12'h004; we = 4'($urandom_range(1, 15));
                    di = $urandom_range(0, 6);
                end
                3: begin
                    cs = 1'b1; addr = 12'h008; we = 4'($urandom_range(1, 15));
                    di = $urandom_range(0, 6);
                end
                4: begin
                    cs = 1'b1; addr = 12'hFF8; we = 4'($urandom_range(0, 15)); di = $urandom;
                end
                5: begin
                    if ($urandom_range(0, 9) == 0) begin
                        cs = 1'b1; addr = 12'hFFC; we = 4'($urandom_range(1, 15));
                        di = $urandom_range(0, 1);
                    end
                end
                6: begin
                    cs = 1'b1; addr = 12'($urandom); we = 4'($urandom_range(1, 15)); di = $urandom;
                end
                7, 8, 9, 10: begin
                    logic [9:0] w;
                    case ($urandom_range(0, 6))
                        0: w = 10'h000;
                        1: w = 10'h001;
                        2: w = 10'h002;
                        3: w = 10'h003;
                        4: w = 10'h3FE;
                        5: w = 10'h3FF;
                        default: w = 10'($urandom);
                    endcase
                    cs = 1'b1; we = 4'b0000; addr = {w, 2'($urandom)};
                end
                default: ;
            endcase
            @(negedge clk);
        end
        cs = 1'b0; we = 4'b0000; rst = 1'b0; wfi = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
